// File: rtl/tlvds_pattern_gen_pkg.sv
// tlvds_pattern_gen_pkg: mode/state encodings, PRBS7 taps and LFSR step shared by the pattern generator
package tlvds_pattern_gen_pkg;
  typedef enum logic [1:0] {MODE_TOGGLE = 2'd0, MODE_PRBS7 = 2'd1, MODE_CONST = 2'd2, MODE_WALK = 2'd3} mode_e;
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, DRIVE = 2'd2, DRAIN = 2'd3} state_e;
  localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;
  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction
endpackage

// File: rtl/tlvds_pattern_lane.sv
// tlvds_pattern_lane: one lane pattern register + tristate pair (clk/rst, mode_q, load, tick, walk_in, oe in; data, tlvds_p/tlvds_n out)
module tlvds_pattern_lane
  import tlvds_pattern_gen_pkg::*;
#(
  parameter int   LANE      = 0,
  parameter logic CONST_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode_q,
  input  logic       load,
  input  logic       tick,
  input  logic       walk_in,
  input  logic       oe,
  output logic       data,
  output logic       tlvds_p,
  output logic       tlvds_n
);
  localparam logic [6:0] SEED     = 7'(LANE + 1);
  localparam logic       TOG_INIT = 1'(LANE % 2);
  logic [6:0] lfsr_q, lfsr_d, lfsr_nx;
  logic       data_q, data_d;
  always_comb begin
    lfsr_nx = prbs7_next(lfsr_q == '0 ? SEED : lfsr_q);
    lfsr_d  = load ? SEED : (tick && mode_q == MODE_PRBS7) ? lfsr_nx : lfsr_q;
    data_d  = data_q;
    if (load)
      data_d = mode_q == MODE_TOGGLE ? TOG_INIT : mode_q == MODE_PRBS7 ? SEED[6] :
               mode_q == MODE_CONST ? CONST_BIT : walk_in;
    else if (tick)
      data_d = mode_q == MODE_TOGGLE ? ~data_q : mode_q == MODE_PRBS7 ? lfsr_nx[6] :
               mode_q == MODE_CONST ? data_q : walk_in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
      data_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      data_q <= data_d;
    end
  end
  assign data    = data_q;
  assign tlvds_p = oe ? data_q : 1'bz;
  assign tlvds_n = oe ? ~data_q : 1'bz;
endmodule

// File: rtl/tlvds_pattern_gen.sv
// tlvds_pattern_gen: N-lane TLVDS test-pattern driver (clk/rst, en, mode, div in; busy, lane_data, lane_oe, tlvds_p/tlvds_n out)
module tlvds_pattern_gen
  import tlvds_pattern_gen_pkg::*;
#(
  parameter int                   N_LANES   = 4,
  parameter int                   DIV_W     = 8,
  parameter int                   ARM_CYC   = 4,
  parameter logic [N_LANES-1:0]   CONST_PAT = N_LANES'(4'b1010)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   div,
  output logic               busy,
  output logic [N_LANES-1:0] lane_data,
  output logic               lane_oe,
  output logic [N_LANES-1:0] tlvds_p,
  output logic [N_LANES-1:0] tlvds_n
);
  localparam int AW = ARM_CYC > 1 ? $clog2(ARM_CYC) : 1;
  state_e             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d, div_q, div_d;
  logic [1:0]         mode_q, mode_d;
  logic [AW-1:0]      arm_q, arm_d;
  logic               oe_q, oe_d, busy_q, busy_d;
  logic               tick, load, adv;
  logic [N_LANES-1:0] walk_in;
  always_comb begin
    tick    = cnt_q == div_q;
    load    = state_q == IDLE && en;
    adv     = state_q == DRIVE && tick;
    mode_d  = load ? mode : mode_q;
    div_d   = load ? div : div_q;
    cnt_d   = (load || tick) ? '0 : cnt_q + 1'b1;
    arm_d   = state_q == ARM ? arm_q + 1'b1 : '0;
    state_d = state_q == IDLE  ? (en ? ARM : IDLE) :
              state_q == ARM   ? (arm_q == AW'(ARM_CYC - 1) ? DRIVE : ARM) :
              state_q == DRIVE ? (en ? DRIVE : DRAIN) :
                                 (en ? DRIVE : tick ? IDLE : DRAIN);
    oe_d    = state_d == DRIVE || state_d == DRAIN;
    busy_d  = state_d != IDLE;
    walk_in = load ? N_LANES'(1) : (lane_data << 1) | (lane_data >> (N_LANES - 1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      mode_q  <= '0;
      arm_q   <= '0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      arm_q   <= arm_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
    end
  end
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    tlvds_pattern_lane #(.LANE(i), .CONST_BIT(CONST_PAT[i])) u_lane (
      .clk    (clk),
      .rst    (rst),
      .mode_q (mode_d),
      .load   (load),
      .tick   (adv),
      .walk_in(walk_in[i]),
      .oe     (oe_q),
      .data   (lane_data[i]),
      .tlvds_p(tlvds_p[i]),
      .tlvds_n(tlvds_n[i])
    );
  end
  assign busy    = busy_q;
  assign lane_oe = oe_q;
endmodule

// File: tb/tb_tlvds_pattern_gen.sv
// tb_tlvds_pattern_gen: randomized self-checking bench against a cycle-level behavioural model
module tb_tlvds_pattern_gen;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int AC = 4;
  localparam logic [N-1:0] CP = 4'b1010;
  localparam int W = N + 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [DW-1:0] div = '0;
  wire busy, lane_oe;
  wire [N-1:0] lane_data, tlvds_p, tlvds_n;
  int checks = 0;
  int failures = 0;
  bit prbs_b[N][600];
  logic [W-1:0] obs_q[$];
  logic [W-1:0] exp_q[$];

  tlvds_pattern_gen #(.N_LANES(N), .DIV_W(DW), .ARM_CYC(AC), .CONST_PAT(CP)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .div(div), .busy(busy),
    .lane_data(lane_data), .lane_oe(lane_oe), .tlvds_p(tlvds_p), .tlvds_n(tlvds_n)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] exp_data(input logic [1:0] m, input int n);
    logic [N-1:0] e;
    for (int i = 0; i < N; i++)
      e[i] = m == 2'd0 ? 1'((i % 2) ^ (n % 2)) : m == 2'd1 ? prbs_b[i][n] : m == 2'd2 ? CP[i] : 1'(((n % N) == i));
    return e;
  endfunction

  task automatic run_seq(input logic [1:0] m, input int d, input int c_drop, input int reen, output int drain_oe);
    int c, n, ph;
    bit en_s, tk, pad_ok;
    obs_q.delete();
    exp_q.delete();
    drain_oe = 0;
    en = 1'b1;
    mode = m;
    div = DW'(d);
    step();
    c = 1;
    n = 0;
    ph = 1;
    while (c < 3000) begin
      pad_ok = !lane_oe || (tlvds_p === lane_data && tlvds_n === ~lane_data);
      obs_q.push_back({busy, lane_oe, lane_data, pad_ok});
      exp_q.push_back({ph != 0, ph >= 2, exp_data(m, n), 1'b1});
      if (c > c_drop && lane_oe === 1'b1) drain_oe++;
      if (ph == 0) break;
      en_s = (c < c_drop) || (reen > 0 && c >= c_drop + reen && c < c_drop + reen + 8);
      en = en_s;
      mode = 2'($urandom);
      div = DW'($urandom);
      tk = ((c - 1) % (d + 1)) == d;
      if (ph == 1) begin
        if (c == AC) ph = 2;
      end else if (ph == 2) begin
        if (tk) n++;
        if (!en_s) ph = 3;
      end else if (ph == 3) begin
        if (en_s) ph = 2;
        else if (tk) ph = 0;
      end
      step();
      c++;
    end
    en = 1'b0;
    if (c >= 3000) begin
      failures++;
      $display("FAIL run_timeout got=busy_forever required=return_to_idle");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy); end
    checks++;
    if (lane_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b required=0", lane_oe); end
    checks++;
    if (lane_data !== '0) begin failures++; $display("FAIL reset_data got=%b required=0", lane_data); end
  endtask

  task automatic test_toggle();
    int doe;
    run_seq(2'd0, 3, 30, 0, doe);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL toggle cyc=%0d got=%b required=%b", i + 1, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (obs_q[0][N:1] !== 4'b1010) begin failures++; $display("FAIL toggle_init got=%b required=1010", obs_q[0][N:1]); end
    checks++;
    if (obs_q[8][N:1] !== 4'b0101) begin failures++; $display("FAIL toggle_first_tick got=%b required=0101", obs_q[8][N:1]); end
    checks++;
    if (obs_q[0][W-1] !== 1'b1 || obs_q[AC-1][W-2] !== 1'b0 || obs_q[AC][W-2] !== 1'b1) begin
      failures++;
      $display("FAIL toggle_latency got=busy%b oe_c4=%b oe_c5=%b required=1,0,1", obs_q[0][W-1], obs_q[AC-1][W-2], obs_q[AC][W-2]);
    end
  endtask

  task automatic test_prbs();
    int doe;
    run_seq(2'd1, 0, AC + 1 + 270, 0, doe);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL prbs cyc=%0d got=%b required=%b", i + 1, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_walk();
    int doe;
    run_seq(2'd3, 1, 30, 0, doe);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL walk cyc=%0d got=%b required=%b", i + 1, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_drain();
    int doe;
    run_seq(2'($urandom), 7, 18, 0, doe);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL drain cyc=%0d got=%b required=%b", i + 1, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (doe !== 6) begin failures++; $display("FAIL drain_oe_cycles got=%0d required=6", doe); end
  endtask

  task automatic test_reen();
    int doe;
    run_seq(2'd0, 7, 17, 3, doe);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL reen cyc=%0d got=%b required=%b", i + 1, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_const();
    int doe;
    run_seq(2'd2, int'($urandom_range(0, 3)), 20, 0, doe);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL const cyc=%0d got=%b required=%b", i + 1, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_rst_mid();
    en = 1'b1;
    mode = 2'd0;
    div = 8'd2;
    for (int i = 0; i < AC + 6; i++) step();
    checks++;
    if (lane_oe !== 1'b1) begin failures++; $display("FAIL rst_mid_pre_oe got=%b required=1", lane_oe); end
    rst = 1'b1;
    step();
    checks++;
    if ({busy, lane_oe, lane_data} !== '0) begin failures++; $display("FAIL rst_mid got=%b required=0", {busy, lane_oe, lane_data}); end
    en = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_random();
    int doe, d, cd, re;
    logic [1:0] m;
    for (int k = 0; k < 8; k++) begin
      m = 2'($urandom);
      d = int'($urandom_range(0, 4));
      cd = AC + 1 + int'($urandom_range(0, 30));
      re = int'($urandom_range(0, 3));
      run_seq(m, d, cd, re, doe);
      foreach (obs_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL random run=%0d mode=%0d div=%0d cyc=%0d got=%b required=%b", k, m, d, i + 1, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 7; k++) prbs_b[i][k] = 1'(((i + 1) >> (6 - k)) & 1);
      for (int k = 7; k < 600; k++) prbs_b[i][k] = prbs_b[i][k-7] ^ prbs_b[i][k-6];
    end
    test_reset();
    test_toggle();
    test_prbs();
    test_walk();
    test_drain();
    test_reen();
    test_const();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tlvds_pattern_gen.md
Name: tlvds_pattern_gen

Overview:
- Multi-lane successor to the single-lane TLVDS tristate demo.
- Drives N true-LVDS tristate pairs with a selectable test pattern (toggle, PRBS7, constant, walking-one) at a programmable bit rate.
- Output-enable sequencing is handled by an FSM: an arm phase before drive, and a drain phase that finishes the current bit before returning to high-Z.
- Sits at the top of board-level I/O bring-up designs, between user controls and the TLVDS_TBUF pad primitives.

Parameters:
- N_LANES, 4, number of differential output pairs (1..16).
- DIV_W, 8, width of the bit-period divider input.
- ARM_CYC, 4, cycles the data is held stable with buffers still in high-Z before drive (>=1).
- CONST_PAT, 4'b1010, per-lane level in CONST mode (width N_LANES).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  drive request; level-sensitive.
- mode  in  2  0=TOGGLE, 1=PRBS7, 2=CONST, 3=WALK; sampled in IDLE only.
- div  in  DIV_W  bit period = div+1 clk cycles; sampled in IDLE only.
- busy  out  1  high in every state except IDLE.
- lane_data  out  N_LANES  registered data presented to the buffer I inputs.
- lane_oe  out  1  registered output enable (1 = driving); the pad OEN is ~lane_oe.
- tlvds_p  out  N_LANES  true side of the pairs.
- tlvds_n  out  N_LANES  complement side of the pairs.

Behaviour:
- Reset values: state=IDLE; busy=0; lane_oe=0; lane_data=0; divider count=0; PRBS registers = seeds.
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Prescaler: cnt counts 0..div_q.
  - tick is asserted in the cycle cnt==div_q; cnt returns to 0 on the following edge.
  - div_q=0 gives a tick every cycle.
  - cnt is cleared when entering ARM.
- FSM states:
  - IDLE: lane_oe=0, busy=0. If en=1, latch mode and div into mode_q/div_q, load the initial pattern, and go to ARM.
  - ARM: lane_oe=0, busy=1, data held at the initial pattern, no pattern advance. After ARM_CYC cycles in ARM, go to DRIVE.
  - DRIVE: lane_oe=1; the pattern advances on every tick. If en=0, go to DRAIN.
  - DRAIN: lane_oe=1, data frozen. On the next tick go to IDLE (lane_oe=0 from the following cycle). If en=1 reappears, return to DRIVE without re-arming.
- Latency: en rises at edge t -> busy=1 at t+1 -> lane_oe=1 at t+1+ARM_CYC.
- Initial pattern and per-tick update, per lane i:
  - TOGGLE: init i[0]; each tick invert.
  - PRBS7: per-lane 7-bit LFSR, x^7+x^6+1, seed = i+1 (never zero), output bit 6, shift on each tick. An all-zero state is forced to the seed.
  - CONST: CONST_PAT[i]; the tick has no effect.
  - WALK: one-hot, lane 0 set initially; rotate toward the higher lane index on each tick, wrapping N-1 -> 0. With N_LANES=1 the output stays 1.
- Changes on mode or div outside IDLE are ignored.
- rst asserted in any state, including mid-DRIVE: next cycle is the reset state, so buffers go to high-Z within 1 cycle.
- Pads: one TLVDS_TBUF per lane with I=lane_data[i], OEN=~lane_oe, O=tlvds_p[i], OB=tlvds_n[i].

Decomposition:
- Shared package holds:
  - mode encodings MODE_TOGGLE/PRBS7/CONST/WALK;
  - state encodings IDLE/ARM/DRIVE/DRAIN;
  - PRBS7 tap constant.
- Sub-module tlvds_pattern_lane: one lane's pattern register and update logic, plus its TLVDS_TBUF. Parametrised by lane index; inputs mode_q, load, tick, oe.
- Top module holds the prescaler, the FSM and the WALK rotation. WALK is cross-lane, so each lane gets a walk_in bit from the top.

Test Plan:
- rst, then en=1, mode=0, div=3, N_LANES=4, ARM_CYC=4 -> busy at +1, lane_oe at +5, lane_data 4'b1010 then 4'b0101, toggling every 4 clk.
- mode=1, div=0 -> lane 0 emits 127-bit PRBS7 sequence from seed 1, repeating exactly at bit 128; never stalls at zero.
- mode=3, div=1 -> lane_data 0001,0010,0100,1000,0001, changing every 2 clk.
- In DRIVE with div=7, drop en 2 clk after a tick -> lane_oe stays 1 until the next tick (6 clk later), then 0; busy falls the same cycle.
- Change mode/div during DRIVE -> no effect. Assert rst mid-DRIVE -> lane_oe=0, lane_data=0, busy=0 on the next edge.
- mode=2 -> lane_data == CONST_PAT throughout DRIVE; tlvds_n == ~tlvds_p whenever lane_oe=1; pads high-Z in IDLE and ARM.
